// File: rtl/rr_bus_arbiter_if.sv
// Bus-side signals of the round-robin/fixed-priority arbiter.
// The requesters use the master view and the arbiter uses the slave view.
interface rr_bus_arbiter_if #(
  parameter int NUM_MASTERS = 8,
  parameter int CNT_W       = 32
);
  localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [NUM_MASTERS-1:0] request;
  logic [NUM_MASTERS-1:0] grant;
  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;
  logic [CNT_W-1:0]       grant_count;
  logic                   done;

  modport master (
    output request,
    input  grant, grant_valid, grant_id, grant_count, done
  );

  modport slave (
    input  request,
    output grant, grant_valid, grant_id, grant_count, done
  );
endinterface

// File: rtl/rr_bus_arbiter.sv
// N-master bus arbiter with a grant-hold limit and a saturating grant counter.
// A change of owner always passes through one idle cycle.
module rr_bus_arbiter #(
  parameter int NUM_MASTERS = 8,
  parameter int RR_MODE     = 1,
  parameter int MAX_HOLD    = 4,
  parameter int CNT_W       = 32,
  parameter int MAX_GRANTS  = 1024
) (
  input  logic           clk,
  input  logic           rst,
  rr_bus_arbiter_if.slave bus
);
  localparam int ID_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t                 state_r;
  logic [NUM_MASTERS-1:0] grant_r;
  logic                   grant_valid_r;
  logic [ID_W-1:0]        grant_id_r;
  logic [ID_W-1:0]        rr_ptr_r;
  logic [HOLD_W-1:0]      hold_cnt_r;
  logic [CNT_W-1:0]       grant_count_r;

  logic [ID_W-1:0]        cand_s;
  logic [ID_W-1:0]        winner_s;
  logic                   winner_found_s;
  logic [ID_W-1:0]        rr_next_s;
  logic                   owner_req_s;
  logic                   others_req_s;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [ID_W-1:0] idx);
    logic [NUM_MASTERS-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Winner search starting at rr_ptr; the pointer never moves in fixed mode,
  // so the same scan yields the lowest set index there.
  always_comb begin
    cand_s         = '0;
    winner_s       = '0;
    winner_found_s = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      cand_s = ID_W'((int'(rr_ptr_r) + i) % NUM_MASTERS);
      if (!winner_found_s && bus.request[cand_s]) begin
        winner_s       = cand_s;
        winner_found_s = 1'b1;
      end else begin
        winner_found_s = winner_found_s;
      end
    end
  end

  // Pointer successor and owner/others request summaries.
  always_comb begin
    if (winner_s == ID_W'(NUM_MASTERS - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = winner_s + ID_W'(1);
    end
    owner_req_s  = |(bus.request & grant_r);
    others_req_s = |(bus.request & ~grant_r);
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_r       <= '0;
      grant_valid_r <= 1'b0;
      grant_id_r    <= '0;
      rr_ptr_r      <= '0;
      hold_cnt_r    <= '0;
      grant_count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (winner_found_s) begin
            state_r       <= OWN;
            grant_r       <= onehot(winner_s);
            grant_valid_r <= 1'b1;
            grant_id_r    <= winner_s;
            hold_cnt_r    <= HOLD_W'(1);
            if (grant_count_r != '1) begin
              grant_count_r <= grant_count_r + CNT_W'(1);
            end else begin
              grant_count_r <= grant_count_r;
            end
            if (RR_MODE != 0) begin
              rr_ptr_r <= rr_next_s;
            end else begin
              rr_ptr_r <= rr_ptr_r;
            end
          end else begin
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            grant_id_r    <= '0;
          end
        end
        OWN: begin
          // Owner drop, or hold limit reached while someone else waits.
          if (!owner_req_s ||
              ((hold_cnt_r == HOLD_W'(MAX_HOLD)) && others_req_s)) begin
            state_r       <= IDLE;
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            grant_id_r    <= '0;
            hold_cnt_r    <= '0;
          end else if (hold_cnt_r != HOLD_W'(MAX_HOLD)) begin
            hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
          end else begin
            hold_cnt_r <= hold_cnt_r;
          end
        end
        default: begin
          state_r       <= IDLE;
          grant_r       <= '0;
          grant_valid_r <= 1'b0;
          grant_id_r    <= '0;
          hold_cnt_r    <= '0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_valid = grant_valid_r;
  assign bus.grant_id    = grant_id_r;
  assign bus.grant_count = grant_count_r;
  // Compared in 64 bits so a MAX_GRANTS wider than the counter never truncates.
  assign bus.done        = (64'(grant_count_r) >= 64'(MAX_GRANTS));
endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Scoreboard bench: three arbiters (round-robin, fixed priority, 4-bit counter)
// share one clock; stimulus queues expected grants, a negedge monitor checks them.
module tb_rr_bus_arbiter;
  typedef struct {
    int id;
    int cnt;
    int len;
    int dn;
  } exp_t;

  logic clk = 1'b0;
  logic rst_rr;
  logic rst_fx;
  logic rst_sat;

  int n_pass  = 0;
  int n_total = 0;

  exp_t       sbq [3][$];
  logic [7:0] prev_g [3];
  int         run_len [3];
  int         exp_len [3];

  rr_bus_arbiter_if #(.NUM_MASTERS(8), .CNT_W(32)) bus_rr ();
  rr_bus_arbiter_if #(.NUM_MASTERS(8), .CNT_W(32)) bus_fx ();
  rr_bus_arbiter_if #(.NUM_MASTERS(8), .CNT_W(4))  bus_sat ();

  rr_bus_arbiter #(.NUM_MASTERS(8), .RR_MODE(1), .MAX_HOLD(4), .CNT_W(32), .MAX_GRANTS(1024))
    dut_rr (.clk(clk), .rst(rst_rr), .bus(bus_rr));
  rr_bus_arbiter #(.NUM_MASTERS(8), .RR_MODE(0), .MAX_HOLD(4), .CNT_W(32), .MAX_GRANTS(1024))
    dut_fx (.clk(clk), .rst(rst_fx), .bus(bus_fx));
  rr_bus_arbiter #(.NUM_MASTERS(8), .RR_MODE(1), .MAX_HOLD(4), .CNT_W(4), .MAX_GRANTS(10))
    dut_sat (.clk(clk), .rst(rst_sat), .bus(bus_sat));

  always #5 clk = ~clk;

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL dut%0d %s: got %0d, expected %0d", k, name, act, exp);
  endtask

  task automatic push(input int k, input int id, input int cnt, input int len, input int dn);
    exp_t e;
    e.id  = id;
    e.cnt = cnt;
    e.len = len;
    e.dn  = dn;
    sbq[k].push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mon(input int k, input logic [7:0] g, input logic gv, input logic [2:0] gid,
                     input logic [31:0] cnt, input logic dn);
    int   idx;
    exp_t e;
    idx = 0;
    for (int i = 0; i < 8; i++) if (g[i]) idx = i;
    chk(k, "grant_onehot0", 32'($onehot0(g)), 32'd1);
    chk(k, "grant_valid", 32'(gv), 32'(|g));
    chk(k, "grant_id", 32'(gid), idx);
    if (prev_g[k] != 8'h00 && g != prev_g[k]) begin
      chk(k, "idle_between_owners", 32'(g), 32'd0);
      if (exp_len[k] != 0) chk(k, "hold_len", run_len[k], exp_len[k]);
    end
    if (g != 8'h00 && g != prev_g[k]) begin
      if (sbq[k].size() == 0) begin
        n_total++;
        $display("FAIL dut%0d unexpected_grant: got id %0d, expected no grant", k, idx);
        exp_len[k] = 0;
      end else begin
        e = sbq[k].pop_front();
        chk(k, "new_grant_id", idx, e.id);
        chk(k, "new_grant_count", cnt, e.cnt);
        chk(k, "new_grant_done", 32'(dn), e.dn);
        exp_len[k] = e.len;
      end
      run_len[k] = 1;
    end else if (g != 8'h00) begin
      run_len[k] = run_len[k] + 1;
    end
    prev_g[k] = g;
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge clk) begin
    mon(0, bus_rr.grant,  bus_rr.grant_valid,  bus_rr.grant_id,  bus_rr.grant_count,       bus_rr.done);
    mon(1, bus_fx.grant,  bus_fx.grant_valid,  bus_fx.grant_id,  bus_fx.grant_count,       bus_fx.done);
    mon(2, bus_sat.grant, bus_sat.grant_valid, bus_sat.grant_id, 32'(bus_sat.grant_count), bus_sat.done);
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, expected run to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      prev_g[k]  = 8'h00;
      run_len[k] = 0;
      exp_len[k] = 0;
    end
    rst_rr = 1'b1; rst_fx = 1'b1; rst_sat = 1'b1;
    bus_rr.request = 8'hFF; bus_fx.request = 8'hFF; bus_sat.request = 8'hFF;

    // Reset with every master requesting.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(0, "reset_grant", 32'(bus_rr.grant), 32'd0);
    chk(0, "reset_count", bus_rr.grant_count, 32'd0);
    chk(0, "reset_done", 32'(bus_rr.done), 32'd0);
    chk(1, "reset_grant", 32'(bus_fx.grant), 32'd0);
    chk(2, "reset_count", 32'(bus_sat.grant_count), 32'd0);
    tick();
    bus_rr.request = 8'h00; bus_fx.request = 8'h00; bus_sat.request = 8'h00;
    tick();
    rst_rr = 1'b0; rst_fx = 1'b0; rst_sat = 1'b0;
    tick();

    // Single master holds the bus alone; no re-count, release one cycle after drop.
    bus_rr.request = 8'h04;
    push(0, 2, 1, 10, 0);
    tick(10);
    bus_rr.request = 8'h00;
    @(negedge clk);
    chk(0, "single_hold_grant", 32'(bus_rr.grant), 32'h04);
    chk(0, "single_hold_count", bus_rr.grant_count, 32'd1);
    tick();
    @(negedge clk);
    chk(0, "single_release", 32'(bus_rr.grant), 32'd0);

    // Owner 2 drops as master 5 rises: one idle cycle, then master 5.
    bus_rr.request = 8'h04;
    push(0, 2, 2, 3, 0);
    tick(3);
    bus_rr.request = 8'h20;
    push(0, 5, 3, 2, 0);
    tick();
    @(negedge clk);
    chk(0, "handover_idle", 32'(bus_rr.grant), 32'd0);
    tick();
    @(negedge clk);
    chk(0, "handover_grant", 32'(bus_rr.grant), 32'h20);
    tick();
    bus_rr.request = 8'h00;
    tick();

    // Round-robin fairness from a freshly reset pointer, all masters requesting.
    rst_rr = 1'b1;
    tick();
    rst_rr = 1'b0;
    bus_rr.request = 8'hFF;
    for (int i = 0; i < 9; i++) push(0, i % 8, i + 1, (i < 8) ? 4 : 1, 0);
    tick(40);
    @(negedge clk);
    chk(0, "rr_after8_count", bus_rr.grant_count, 32'd8);
    chk(0, "rr_after8_idle", 32'(bus_rr.grant), 32'd0);
    tick();
    bus_rr.request = 8'h00;
    tick(2);

    // Fixed priority: master 0 re-wins each arbitration while held.
    bus_fx.request = 8'h81;
    for (int i = 1; i <= 4; i++) push(1, 0, i, (i < 4) ? 4 : 1, 0);
    tick(16);
    bus_fx.request = 8'h80;
    push(1, 7, 5, 2, 0);
    tick(3);
    bus_fx.request = 8'h00;
    tick(2);

    // 4-bit counter: done at 10 grants, saturation at 15, reset mid-grant.
    bus_sat.request = 8'h03;
    for (int i = 1; i <= 17; i++) begin
      int c;
      c = (i < 15) ? i : 15;
      push(2, (i - 1) % 2, c, (i < 17) ? 4 : 1, (c >= 10) ? 1 : 0);
    end
    tick(81);
    rst_sat = 1'b1;
    tick();
    @(negedge clk);
    chk(2, "midgrant_reset_grant", 32'(bus_sat.grant), 32'd0);
    chk(2, "midgrant_reset_count", 32'(bus_sat.grant_count), 32'd0);
    chk(2, "midgrant_reset_done", 32'(bus_sat.done), 32'd0);
    bus_sat.request = 8'h00;
    tick();
    rst_sat = 1'b0;
    tick(3);

    for (int k = 0; k < 3; k++) chk(k, "scoreboard_drained", sbq[k].size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
